// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit of the 16-bit IMUL processor:
// opcodes, register indices, instruction field positions and the fetch FSM states.
package instruction_fetch_unit_pkg;

  localparam int INSTR_W = 28;
  localparam int DELAY_W = 24;

  typedef logic [INSTR_W-1:0] instr_t;

  // Opcodes (instruction bits [27:24])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_STO  = 4'h1;
  localparam logic [3:0] OP_IMUL = 4'h2;
  localparam logic [3:0] OP_LED  = 4'h3;

  // Register indices
  localparam logic [7:0] R0 = 8'd0;
  localparam logic [7:0] R1 = 8'd1;
  localparam logic [7:0] R2 = 8'd2;
  localparam logic [7:0] R3 = 8'd3;

  // Field bit positions
  localparam int OPCODE_MSB = 27;
  localparam int OPCODE_LSB = 24;
  localparam int DEST_MSB   = 23;
  localparam int DEST_LSB   = 16;
  localparam int SRCA_MSB   = 15;
  localparam int SRCA_LSB   = 8;
  localparam int SRCB_MSB   = 7;
  localparam int SRCB_LSB   = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int DELAY_MSB  = 23;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

  // A NOP with a non-zero delay field stalls fetch for that many cycles.
  function automatic logic is_delay_nop(input instr_t instr);
    return (instr[OPCODE_MSB:OPCODE_LSB] == OP_NOP) && (instr[DELAY_MSB:0] != '0);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_delay_counter.sv
// Down-counter that times the fetch hold after a delay NOP.
// Priority: clear > load > decrement; terminal is high when the count is 1.
module fetch_delay_counter #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             decrement,
  input  logic             clear,
  output logic             terminal
);

  logic [WIDTH-1:0] count;

  // Count register: clear, load or step down, saturating at zero.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (decrement && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign terminal = (count == WIDTH'(1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the ROM address from the PC, registers the
// returned word, slices it into decode fields and handles stall, branch
// redirect and delay NOPs that hold fetch for N cycles.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 28,
  parameter int DELAY_WIDTH = 24
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic [ADDR_WIDTH-1:0]  oAddress,
  input  logic [INSTR_WIDTH-1:0] iInstruction,
  input  logic                   iStall,
  input  logic                   iBranchTaken,
  input  logic [ADDR_WIDTH-1:0]  iBranchTarget,
  output logic                   oValid,
  output logic [3:0]             oOpcode,
  output logic [7:0]             oDestination,
  output logic [7:0]             oSourceA,
  output logic [7:0]             oSourceB,
  output logic [15:0]            oImmediate,
  output logic                   oBusy
);

  logic [ADDR_WIDTH-1:0]  pc;
  logic [INSTR_WIDTH-1:0] ir;
  fetch_state_t           state;

  logic fetch_en;
  logic delay_nop;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_terminal;

  assign fetch_en  = (state == RUN) && !iStall && !iBranchTaken;
  assign delay_nop = is_delay_nop(iInstruction);
  assign cnt_load  = fetch_en && delay_nop;
  assign cnt_dec   = (state == WAIT) && !iBranchTaken;

  fetch_delay_counter #(
    .WIDTH(DELAY_WIDTH)
  ) u_delay (
    .clk        (Clock),
    .rst        (Reset),
    .load       (cnt_load),
    .load_value (iInstruction[DELAY_MSB:0]),
    .decrement  (cnt_dec),
    .clear      (iBranchTaken),
    .terminal   (cnt_terminal)
  );

  // Fetch FSM: branch beats wait, wait beats stall, stall beats normal fetch.
  // oBusy marks the cycles in which the delay holds issue off.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc     <= '0;
      ir     <= '0;
      oValid <= 1'b0;
      oBusy  <= 1'b0;
      state  <= RUN;
    end else if (iBranchTaken) begin
      pc     <= iBranchTarget;
      oValid <= 1'b0;
      oBusy  <= 1'b0;
      state  <= RUN;
    end else if (state == WAIT) begin
      oValid <= 1'b0;
      oBusy  <= 1'b1;
      if (cnt_terminal) state <= RUN;
    end else if (!iStall) begin
      ir     <= iInstruction;
      oValid <= 1'b1;
      oBusy  <= 1'b0;
      pc     <= pc + ADDR_WIDTH'(1);
      if (delay_nop) state <= WAIT;
    end
  end

  assign oAddress     = pc;
  assign oOpcode      = ir[OPCODE_MSB:OPCODE_LSB];
  assign oDestination = ir[DEST_MSB:DEST_LSB];
  assign oSourceA     = ir[SRCA_MSB:SRCA_LSB];
  assign oSourceB     = ir[SRCB_MSB:SRCB_LSB];
  assign oImmediate   = ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit with a combinational model ROM.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        iStall;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic        oValid;
  logic [3:0]  oOpcode;
  logic [7:0]  oDestination;
  logic [7:0]  oSourceA;
  logic [7:0]  oSourceB;
  logic [15:0] oImmediate;
  logic        oBusy;

  logic [27:0] rom [0:65535];

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch_unit dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .oAddress      (oAddress),
    .iInstruction  (iInstruction),
    .iStall        (iStall),
    .iBranchTaken  (iBranchTaken),
    .iBranchTarget (iBranchTarget),
    .oValid        (oValid),
    .oOpcode       (oOpcode),
    .oDestination  (oDestination),
    .oSourceA      (oSourceA),
    .oSourceB      (oSourceB),
    .oImmediate    (oImmediate),
    .oBusy         (oBusy)
  );

  assign iInstruction = rom[oAddress];

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample on the falling edge.
  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    Reset         = 1'b1;
    iStall        = 1'b0;
    iBranchTaken  = 1'b0;
    iBranchTarget = '0;
    // Default word: LED with the address as immediate, never a delay NOP.
    for (int a = 0; a < 65536; a++) rom[a] = {OP_LED, 8'd0, a[15:0]};
    rom[0] = {OP_STO, R1, 16'd10};

    // Reset state
    @(negedge Clock);
    check("rst_addr",   oAddress, 0);
    check("rst_valid",  oValid,   0);
    check("rst_busy",   oBusy,    0);
    check("rst_opcode", oOpcode,  0);
    Reset = 1'b0;
    check("t1_addr0", oAddress, 0);

    // First fetch after reset
    step();
    check("t1_addr1",  oAddress,     16'd1);
    check("t1_valid",  oValid,       1);
    check("t1_opcode", oOpcode,      OP_STO);
    check("t1_dest",   oDestination, R1);
    check("t1_imm",    oImmediate,   16'd10);
    step();
    check("t1_addr2",  oAddress,     16'd2);
    check("t1_imm1",   oImmediate,   16'd1);

    // Asynchronous reset, then delay NOP of 3 at address 0
    Reset = 1'b1;
    #1;
    check("t2_async_addr",   oAddress,   0);
    check("t2_async_valid",  oValid,     0);
    check("t2_async_opcode", oOpcode,    0);
    check("t2_async_imm",    oImmediate, 0);
    rom[0] = {OP_NOP, 24'd3};
    rom[1] = {OP_IMUL, R3, R1, R2};
    @(negedge Clock);
    Reset = 1'b0;
    step();
    check("t2_nop_valid",  oValid,   1);
    check("t2_nop_opcode", oOpcode,  OP_NOP);
    check("t2_nop_addr",   oAddress, 16'd1);
    check("t2_nop_busy",   oBusy,    0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t2_wait%0d_valid", i), oValid,   0);
      check($sformatf("t2_wait%0d_busy", i),  oBusy,    1);
      check($sformatf("t2_wait%0d_addr", i),  oAddress, 16'd1);
    end
    step();
    check("t2_imul_valid",  oValid,       1);
    check("t2_imul_opcode", oOpcode,      OP_IMUL);
    check("t2_imul_dest",   oDestination, R3);
    check("t2_imul_srca",   oSourceA,     R1);
    check("t2_imul_srcb",   oSourceB,     R2);
    check("t2_imul_busy",   oBusy,        0);
    check("t2_imul_addr",   oAddress,     16'd2);

    // Stall for 2 cycles at PC = 5
    step(); step(); step();
    check("t3_pre_addr", oAddress,   16'd5);
    check("t3_pre_imm",  oImmediate, 16'd4);
    iStall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("t3_stall%0d_addr", i),  oAddress,   16'd5);
      check($sformatf("t3_stall%0d_imm", i),   oImmediate, 16'd4);
      check($sformatf("t3_stall%0d_valid", i), oValid,     1);
    end
    iStall = 1'b0;
    step();
    check("t3_resume_addr", oAddress,   16'd6);
    check("t3_resume_imm",  oImmediate, 16'd5);

    // Branch together with stall: branch wins
    rom[16'h0040] = {OP_STO, R2, 16'h1234};
    iBranchTaken  = 1'b1;
    iBranchTarget = 16'h0040;
    iStall        = 1'b1;
    step();
    check("t4_br_addr",  oAddress, 16'h0040);
    check("t4_br_valid", oValid,   0);
    iBranchTaken = 1'b0;
    iStall       = 1'b0;
    step();
    check("t4_tgt_valid",  oValid,       1);
    check("t4_tgt_opcode", oOpcode,      OP_STO);
    check("t4_tgt_dest",   oDestination, R2);
    check("t4_tgt_imm",    oImmediate,   16'h1234);
    check("t4_tgt_addr",   oAddress,     16'h0041);

    // Ordinary NOP (delay 0) does not enter WAIT
    rom[16'h0060] = '0;
    iBranchTaken  = 1'b1;
    iBranchTarget = 16'h0060;
    step();
    iBranchTaken = 1'b0;
    step();
    check("nop0_valid",  oValid,   1);
    check("nop0_opcode", oOpcode,  OP_NOP);
    check("nop0_busy",   oBusy,    0);
    check("nop0_addr",   oAddress, 16'h0061);
    step();
    check("nop0_next_valid", oValid,     1);
    check("nop0_next_busy",  oBusy,      0);
    check("nop0_next_addr",  oAddress,   16'h0062);
    check("nop0_next_imm",   oImmediate, 16'h0061);

    // Branch aborts a long delay wait
    rom[16'h0050] = {OP_NOP, 24'd4000};
    iBranchTaken  = 1'b1;
    iBranchTarget = 16'h0050;
    step();
    iBranchTaken = 1'b0;
    step();
    check("t5_nop_opcode", oOpcode,  OP_NOP);
    check("t5_nop_valid",  oValid,   1);
    check("t5_nop_addr",   oAddress, 16'h0051);
    step(); step();
    check("t5_wait_busy",  oBusy,    1);
    check("t5_wait_valid", oValid,   0);
    check("t5_wait_addr",  oAddress, 16'h0051);
    iBranchTaken  = 1'b1;
    iBranchTarget = 16'h0010;
    step();
    check("t5_abort_busy",  oBusy,    0);
    check("t5_abort_valid", oValid,   0);
    check("t5_abort_addr",  oAddress, 16'h0010);
    iBranchTaken = 1'b0;
    step();
    check("t5_tgt_valid", oValid,     1);
    check("t5_tgt_imm",   oImmediate, 16'h0010);
    check("t5_tgt_addr",  oAddress,   16'h0011);
    check("t5_tgt_busy",  oBusy,      0);
    step();
    check("t5_run_addr",  oAddress,   16'h0012);
    check("t5_run_valid", oValid,     1);

    // Branch to 0xFFFF and wrap, then reset mid-wait
    iBranchTaken  = 1'b1;
    iBranchTarget = 16'hFFFF;
    step();
    check("t6_addr_ffff", oAddress, 16'hFFFF);
    check("t6_br_valid",  oValid,   0);
    iBranchTaken = 1'b0;
    step();
    check("t6_addr_0000", oAddress,   16'h0000);
    check("t6_imm_ffff",  oImmediate, 16'hFFFF);
    check("t6_valid",     oValid,     1);
    step();
    check("t6_addr_0001", oAddress, 16'h0001);
    check("t6_nop",       oOpcode,  OP_NOP);
    step();
    check("t6_in_wait", oBusy, 1);
    Reset = 1'b1;
    #1;
    check("t6_rst_addr",  oAddress,     0);
    check("t6_rst_valid", oValid,       0);
    check("t6_rst_busy",  oBusy,        0);
    check("t6_rst_op",    oOpcode,      0);
    check("t6_rst_dest",  oDestination, 0);
    check("t6_rst_srca",  oSourceA,     0);
    check("t6_rst_srcb",  oSourceB,     0);
    check("t6_rst_imm",   oImmediate,   0);
    @(negedge Clock);
    Reset = 1'b0;
    step();
    check("t6_post_addr",  oAddress, 16'h0001);
    check("t6_post_valid", oValid,   1);
    check("t6_post_busy",  oBusy,    0);
    check("t6_post_op",    oOpcode,  OP_NOP);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Reader side of the 28-bit instruction ROM interface.
- Drives the ROM address from an internal program counter and registers the returned instruction.
- Splits the instruction into opcode, register and immediate fields for the execute stage.
- Handles stall, branch redirect, and a NOP-encoded delay count that holds fetch for N cycles.
- Sits between the instruction ROM and the execute/register-file stage of the 16-bit IMUL processor.

Parameters:
- ADDR_WIDTH, 16, program counter and ROM address width.
- INSTR_WIDTH, 28, instruction word width.
- DELAY_WIDTH, 24, width of the NOP delay field and of the delay counter.

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- oAddress  output  16  ROM address; equals the PC.
- iInstruction  input  28  combinational ROM data for oAddress.
- iStall  input  1  hold the PC and decoded outputs this cycle.
- iBranchTaken  input  1  single-cycle redirect request from execute.
- iBranchTarget  input  16  new PC when iBranchTaken=1.
- oValid  output  1  decoded fields hold an instruction to issue.
- oOpcode  output  4  instruction bits [27:24].
- oDestination  output  8  bits [23:16].
- oSourceA  output  8  bits [15:8].
- oSourceB  output  8  bits [7:0].
- oImmediate  output  16  bits [15:0].
- oBusy  output  1  high while in WAIT.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - PC = 0, so oAddress = 0.
  - oValid = 0, all decode outputs = 0, oBusy = 0.
  - Delay counter = 0, state = RUN.
  - Reset asserted mid-WAIT or mid-branch aborts immediately to these values.
- States: RUN and WAIT.
- RUN, no stall, no branch, at each rising edge:
  - Instruction register <= iInstruction.
  - oValid <= 1.
  - PC <= PC+1; 16'hFFFF wraps to 0.
- Latency: the instruction at address A appears on the decode outputs exactly one cycle after oAddress = A.
- Decode fields are pure slices of the instruction register; no sign extension.
- Delay NOP: when the word being latched has opcode NOP (4'h0) and bits [23:0] = D:
  - D = 0: ordinary NOP, state stays RUN.
  - D > 0: the NOP itself issues with oValid = 1; counter <= D; next state WAIT.
- WAIT:
  - oValid = 0, oBusy = 1, PC held.
  - Counter decrements by 1 each cycle.
  - When the counter reaches 1, the next state is RUN.
  - Exactly D cycles with oValid = 0 occur after the NOP before the next fetch is latched.
  - iStall is ignored in WAIT.
- iStall = 1 in RUN: PC, instruction register and oValid all hold their values.
- Priority: Reset > iBranchTaken > WAIT > iStall > normal fetch.
- iBranchTaken = 1 (any state) at an edge:
  - PC <= iBranchTarget.
  - oValid <= 0 (flushes the word currently on iInstruction).
  - State <= RUN, counter <= 0.
  - The target instruction appears one cycle later with oValid = 1.
- A branch and a stall in the same cycle: the branch wins.
- A branch while in WAIT: the wait is aborted.
- A branch whose target is 16'hFFFF: fetch proceeds, then wraps to address 0.

Decomposition:
- Shared definitions package holds:
  - Opcode constants (NOP = 4'h0 plus the existing STO, IMUL, LED, ...).
  - Register index constants (R1, R2, R3, ...).
  - Field bit-position constants.
  - State encoding RUN/WAIT.
- Natural sub-module: fetch_delay_counter (DELAY_WIDTH down-counter with load, decrement, clear and a terminal flag).
- PC and decode registers stay in the top module.

Test Plan:
- Reset release with a model ROM returning STO R1,10 at address 0 -> oAddress 0 then 1; next cycle oValid = 1, oOpcode = STO, oDestination = R1, oImmediate = 16'd10.
- ROM addr 0 = NOP 24'd3, addr 1 = IMUL R3,R1,R2 -> NOP issues with oValid = 1, then 3 cycles of oValid = 0 with oBusy = 1 and oAddress held at 1; then IMUL issues with oSourceA = R1, oSourceB = R2.
- iStall high for 2 cycles during RUN at PC = 5 -> oAddress stays 5 and decode outputs are unchanged for 2 cycles; resumes at 6.
- iBranchTaken with target 16'h0040, asserted together with iStall -> next cycle oAddress = 16'h0040 and oValid = 0; following cycle oValid = 1 with ROM[0x40] decoded.
- Branch to 16'h0010 during a NOP 24'd4000 wait -> wait aborted, oBusy = 0 next cycle, fetch from 0x10.
- Branch to 16'hFFFF then run 2 cycles -> oAddress sequence FFFF, 0000, 0001; Reset pulsed mid-sequence -> all outputs 0 asynchronously, before the next clock edge.
